// File: rtl/mpy_seq.sv
// Iterative shift-add multiplier producing a 2*WIDTH-bit signed or unsigned product.
// It uses one partial-product step per clock and a start/busy/done handshake.
module mpy_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state
);

    // Handshake: start is sampled only while IDLE (busy=0). busy rises on the
    // accepting edge and falls on the result edge. done pulses for one cycle
    // in IDLE, coincident with y updating. busy and done are never high together.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [WIDTH-1:0]   ONE_W   = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W  = 1;
    localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // The magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = (sgn && a[WIDTH-1]) ? (~a + ONE_W) : a;
    assign b_mag = (sgn && b[WIDTH-1]) ? (~b + ONE_W) : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    y     <= neg ? (~acc + ONE_2W) : acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mpy_seq.md
# mpy_seq

Parametrised iterative multiplier for the MIPS datapath ALU, the sequential successor to the single-cycle 32×32 combinational multiplier. It computes a full-width 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned per request, using one shift-add step per clock. A start/busy/done handshake lets the controller stall while HI/LO results are produced. The smaller area and shorter critical path cost WIDTH+1 cycles of latency per product.

## Interface
- WIDTH, 32, operand width in bits; product is 2·WIDTH bits; legal range 4..64.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- y  output  2·WIDTH  product; holds the last completed result.
- busy  output  1  high from the accepting edge until the result edge.
- done  output  1  one-cycle pulse coincident with y updating.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1 at an edge:
  - latch |a| and |b| into internal registers; magnitude = two's negation if sgn=1 and the operand MSB=1, otherwise the raw value.
  - latch neg = sgn & (a[MSB] ^ b[MSB]).
  - clear the 2·WIDTH accumulator and the bit counter.
  - go to RUN.
- RUN, each edge:
  - if multiplier LSB=1, accumulator += multiplicand aligned at the current bit.
  - shift the multiplier right by 1 and the multiplicand left by 1 (or the equivalent shifting-accumulator form).
  - counter++.
  - after exactly WIDTH steps, go to FIX.
- FIX, one edge:
  - y ← neg ? −acc : acc, modulo 2^(2·WIDTH).
  - done=1 for that cycle; go to IDLE.
- Arithmetic rules:
  - All internal arithmetic is unsigned, 2·WIDTH bits wide.
  - The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1); this fits WIDTH unsigned bits and needs no extra bit.
  - The result is exact for all operand pairs in both modes, with no overflow.
- start while busy=1 is ignored; the operation in flight is unaffected. a, b and sgn may change freely after the accepting edge.
- y is not disturbed during RUN. It changes only on the FIX edge or on reset.
- Reset mid-operation aborts the operation: state returns to IDLE, y=0, busy=0, done=0, and no done pulse is emitted for the aborted request.

## Timing
- Reset values: y=0, busy=0, done=0, state=IDLE, all internal registers 0.
- Handshake and latency:
  - start accepted at edge k.
  - busy=1 after edge k.
  - RUN occupies edges k+1..k+WIDTH.
  - On edge k+WIDTH+1, y and done=1 are updated and busy=0.
  - Latency is WIDTH+1 cycles from acceptance to result (33 for WIDTH=32).
- Back-to-back:
  - done is asserted while the state is IDLE, so start=1 during the done cycle is accepted at the next edge.
  - Maximum throughput is one product per WIDTH+2 cycles.
- done is high for exactly one cycle per accepted request. busy and done are never high together.
- All outputs are registered; no combinational path runs from any input to any output.

## Test plan
All scenarios use WIDTH=32.
- Reset/idle:
  - assert reset asynchronously between edges → y=0, busy=0, done=0 immediately.
  - release reset and hold start=0 for 50 cycles → no done pulse.
- Unsigned extremes:
  - a=0xFFFFFFFF, b=0xFFFFFFFF, sgn=0 → y=0xFFFFFFFE00000001; done 33 cycles after acceptance; busy high for exactly 33 cycles.
- Signed vs unsigned on the same bits:
  - a=0xFFFFFFFD, b=5, sgn=1 → y=0xFFFFFFFFFFFFFFF1 (−15).
  - same operands, sgn=0 → y=0x00000004FFFFFFF1.
- Signed corners:
  - 0x80000000×0x80000000, sgn=1 → y=0x4000000000000000.
  - 0x80000000×1, sgn=1 → y=0xFFFFFFFF80000000.
  - −1×−1, sgn=1 → y=1.
  - 0×0x7FFFFFFF → y=0.
- Handshake:
  - pulse start again at RUN cycle 10 with different operands → ignored; first result unchanged.
  - start held high during the done cycle → second product accepted; its done arrives 34 cycles after the first done.
- Reset mid-operation:
  - assert reset at RUN cycle 16 → y=0, busy=0, no done.
  - new request a=7, b=6, sgn=0 → y=42 after 33 cycles.
- Random regression: 10k random a, b, sgn compared against a reference model's 64-bit product.
